// File: rtl/jtgng_snd_cmd.sv
// Sound-command channel from the main CPU to the sound Z80: command FIFO (or a
// single latch when FIFO_AW=0), V32-derived INT pulse and optional pending NMI.
module jtgng_snd_cmd #(
    parameter int DW      = 8,
    parameter int FIFO_AW = 2,
    parameter int INT_LEN = 32,
    parameter int NMI_EN  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               main_wr,
    input  logic [DW-1:0]      main_din,
    output logic               main_full,
    input  logic               snd_rd,
    output logic [DW-1:0]      snd_dout,
    output logic               snd_empty,
    output logic [FIFO_AW:0]   level,
    output logic               ovf,
    input  logic               clr_ovf,
    input  logic               V32,
    output logic               int_n,
    output logic               nmi_n
);

    localparam int LW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    logic            rd_last_r;
    logic            pop_s;
    logic [DW-1:0]   dout_r;
    logic            empty_r;
    logic            full_r;
    logic [LW-1:0]   level_r;
    logic            ovf_r;
    logic            v32_last_r;
    logic [7:0]      int_cnt_r;
    logic            int_n_r;
    logic            nmi_n_r;

    // The Z80 read ends on the falling edge of snd_rd, so data stays put during the read
    assign pop_s = rd_last_r & ~snd_rd;

    // snd_rd history for pop-edge detection
    always_ff @(posedge clk) begin
        if (rst) rd_last_r <= 1'b0;
        else     rd_last_r <= snd_rd;
    end

    generate
        if (FIFO_AW > 0) begin : g_fifo
            localparam logic [LW-1:0]      LVL_ONE  = LW'(1);
            localparam logic [LW-1:0]      LVL_ZERO = LW'(0);
            localparam logic [LW-1:0]      LVL_FULL = LW'(DEPTH);
            localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
            localparam logic [FIFO_AW-1:0] PTR_ZERO = FIFO_AW'(0);

            logic [DW-1:0]      mem_r [DEPTH];
            logic [FIFO_AW-1:0] wr_ptr_r;
            logic [FIFO_AW-1:0] rd_ptr_r;
            logic               pop_ok_s;
            logic               push_s;
            logic               ovf_set_s;
            logic [LW-1:0]      level_nxt_s;

            // Accept/drop decision; a full FIFO still takes a write when a pop frees a slot
            always_comb begin
                pop_ok_s    = pop_s && (level_r != LVL_ZERO);
                push_s      = main_wr && (!full_r || pop_ok_s);
                ovf_set_s   = main_wr && full_r && !pop_ok_s;
                level_nxt_s = level_r;
                if (push_s && !pop_ok_s) begin
                    level_nxt_s = level_r + LVL_ONE;
                end else if (pop_ok_s && !push_s) begin
                    level_nxt_s = level_r - LVL_ONE;
                end else begin
                    level_nxt_s = level_r;
                end
            end

            // Storage array; contents are only meaningful between the pointers
            always_ff @(posedge clk) begin
                if (!rst && push_s) mem_r[wr_ptr_r] <= main_din;
            end

            // Pointers, occupancy, overflow flag and the registered head word
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_r <= PTR_ZERO;
                    rd_ptr_r <= PTR_ZERO;
                    level_r  <= LVL_ZERO;
                    full_r   <= 1'b0;
                    empty_r  <= 1'b1;
                    dout_r   <= {DW{1'b0}};
                    ovf_r    <= 1'b0;
                end else begin
                    if (push_s)   wr_ptr_r <= wr_ptr_r + PTR_ONE;
                    if (pop_ok_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
                    level_r <= level_nxt_s;
                    full_r  <= (level_nxt_s == LVL_FULL);
                    empty_r <= (level_r == LVL_ZERO);
                    // Holding dout when empty gives the stale re-read of the old latch
                    if (level_r != LVL_ZERO) dout_r <= mem_r[rd_ptr_r];
                    if (ovf_set_s)    ovf_r <= 1'b1;
                    else if (clr_ovf) ovf_r <= 1'b0;
                end
            end
        end else begin : g_latch
            // Legacy single sound latch with a pending flag
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_r  <= {DW{1'b0}};
                    empty_r <= 1'b1;
                    level_r <= 1'b0;
                end else if (main_wr) begin
                    dout_r  <= main_din;
                    empty_r <= 1'b0;
                    level_r <= 1'b1;
                end else if (pop_s) begin
                    empty_r <= 1'b1;
                    level_r <= 1'b0;
                end
                full_r <= 1'b0;
                ovf_r  <= 1'b0;
            end
        end
    endgenerate

    // V32 falling-edge detector and INT pulse counter, advanced on cen only
    always_ff @(posedge clk) begin
        if (rst) begin
            v32_last_r <= 1'b0;
            int_cnt_r  <= 8'd0;
            int_n_r    <= 1'b1;
        end else if (cen) begin
            v32_last_r <= V32;
            if (v32_last_r && !V32) begin
                int_n_r   <= 1'b0;
                int_cnt_r <= 8'(INT_LEN - 1);
            end else if (!int_n_r) begin
                if (int_cnt_r == 8'd0) int_n_r   <= 1'b1;
                else                   int_cnt_r <= int_cnt_r - 8'd1;
            end
        end
    end

    generate
        if (NMI_EN != 0) begin : g_nmi
            // NMI follows the pending flag one clk later
            always_ff @(posedge clk) begin
                if (rst) nmi_n_r <= 1'b1;
                else     nmi_n_r <= empty_r;
            end
        end else begin : g_no_nmi
            assign nmi_n_r = 1'b1;
        end
    endgenerate

    assign main_full = full_r;
    assign snd_dout  = dout_r;
    assign snd_empty = empty_r;
    assign level     = level_r;
    assign ovf       = ovf_r;
    assign int_n     = int_n_r;
    assign nmi_n     = nmi_n_r;

endmodule

// File: doc/jtgng_snd_cmd.md
Name: jtgng_snd_cmd

Overview:
- Parametrised sound-command channel between the main CPU and the sound Z80.
- Replaces the single 8-bit sound latch with a configurable FIFO; FIFO_AW=0 gives the legacy single-register latch mode.
- Also generates the V32-derived Z80 INT pulse, with configurable length, plus an optional "command pending" NMI.
- Sits between the main-CPU write decode and the sound board's data-in mux / Z80 INT_n / NMI_n.

Parameters:
- DW, 8, command word width.
- FIFO_AW, 2, log2 FIFO depth (depth = 2^FIFO_AW); 0 selects latch mode.
- INT_LEN, 32, INT_n low time in cen ticks, range 1..255.
- NMI_EN, 0, 1 drives nmi_n low while a command is pending.

Ports:
- clk  in  1  system clock (24 MHz)
- rst  in  1  reset, synchronous, active-high
- cen  in  1  sound CPU clock enable (3 MHz); qualifies V32 sampling and the INT counter only
- main_wr  in  1  one-clk write strobe from main CPU
- main_din  in  DW  command data
- main_full  out  1  FIFO full (always 0 in latch mode)
- snd_rd  in  1  level: sound CPU reading the command port (latch_cs & ~rd_n)
- snd_dout  out  DW  head-of-FIFO / latch value
- snd_empty  out  1  no unread command
- level  out  FIFO_AW+1  number of stored entries
- ovf  out  1  sticky overflow flag
- clr_ovf  in  1  clears ovf
- V32  in  1  vertical timing bit
- int_n  out  1  Z80 maskable interrupt, active low
- nmi_n  out  1  Z80 NMI, active low

Behaviour:
- Reset (synchronous, active-high), applied on the clk edge regardless of cen. Result: FIFO empty, level=0, snd_empty=1, main_full=0, snd_dout=0, ovf=0, int_n=1, nmi_n=1. The registered V32 copy is set to 0, so no spurious edge fires after reset. Reset mid-pulse ends INT on the next edge.
- FIFO mode (FIFO_AW>=1):
  - Write: main_wr sampled every clk, independent of cen. If not full, main_din goes to the tail, the write pointer increments (wraps modulo depth) and level increments.
  - Pop: the pop event is the falling edge of snd_rd (registered snd_rd=1, current=0). Data therefore stays stable for the whole Z80 read. A pop when empty is ignored.
  - snd_dout is registered and shows the head entry one clk after it becomes head. When the FIFO is empty it holds the last popped value; a Z80 re-read returns the stale command, as on the original latch.
  - Latency: write at edge t gives snd_empty=0 and snd_dout=data after edge t+1. A pop at edge t presents the next head after edge t+1.
  - Simultaneous write and pop: both are performed and level is unchanged. When full, the write is accepted because a slot frees in the same cycle.
  - Write when full without a pop: data is dropped, ovf is set and the FIFO is unchanged.
  - ovf stays set until clr_ovf. If clr_ovf and a new overflow occur in the same cycle, set wins.
- Latch mode (FIFO_AW=0):
  - main_wr loads snd_dout directly (1 clk latency).
  - snd_empty goes 0 on a write and 1 on the snd_rd falling edge; snd_dout is unaffected by reads.
  - level = ~snd_empty; main_full=0; ovf is never set.
- INT generation (on cen ticks only):
  - A V32 falling edge (last=1, now=0) drives int_n low and loads a counter with INT_LEN-1.
  - Each later cen decrements the counter; int_n returns high on the cen after the counter reads 0. Low time is exactly INT_LEN cen ticks.
  - A new falling edge during a pulse restarts the count, keeping int_n low.
- NMI: with NMI_EN=1, nmi_n = snd_empty, registered (1 clk after snd_empty changes). With NMI_EN=0, nmi_n is tied to 1.
- Width rules: level saturates at 2^FIFO_AW, and its counter never wraps.

Test Plan:
- FIFO_AW=2: write 0x11,0x22,0x33 on consecutive clks, then three snd_rd pulses -> snd_dout 0x11 after the first write. After each pop it shows 0x22, then 0x33, then stays 0x33 with snd_empty=1; level steps 3,2,1,0.
- FIFO_AW=2: five writes with no reads -> level=4, main_full=1, ovf=1, fifth value lost. Then clr_ovf -> ovf=0. Then pop+write in the same clk while full -> level stays 4, the written data comes out last.
- FIFO_AW=0: write 0xA5 -> snd_dout=0xA5, snd_empty=0. snd_rd pulse -> snd_empty=1, snd_dout still 0xA5. Write 0x5A -> snd_dout=0x5A.
- INT_LEN=32: toggle V32 1->0 -> int_n low for exactly 32 cen ticks. A second falling edge at tick 20 -> int_n low for 52 ticks total. Reset at tick 10 -> int_n=1 on the next clk.
- NMI_EN=1: write one command -> nmi_n=0 two clks after main_wr. snd_rd falling edge -> nmi_n=1 two clks later. Read while empty -> no state change.
- Reset with V32=0 held low -> no INT pulse. Release V32 high then low -> a single INT pulse.
